// File: rtl/bls_sub_pipe_if.sv
// Operand/result handshake bundle for bls_sub_pipe.
// slave is the subtractor side, master is the producer/consumer side.
interface bls_sub_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf
  );
endinterface

// File: rtl/bls_sub_pipe.sv
// Pipelined borrow-lookahead subtractor: D = A - B - bin, one GROUP-bit slice per stage,
// borrow registered between stages, valid/ready with a single global advance enable.
module bls_sub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic           clk,
  input logic           rst_n,
  bls_sub_pipe_if.slave bus_io
);

  localparam int unsigned Stages = WIDTH / GROUP;

  // Returns {borrow_out, diff}; each borrow is a flat sum of products, no in-group ripple.
  function automatic logic [GROUP:0] bls_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             bi);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] dv;
    logic [GROUP:0]   brw;
    logic             term;
    g      = ~a & b;
    p      = ~(a ^ b);
    brw    = '0;
    brw[0] = bi;
    for (int i = 0; i < GROUP; i++) begin
      term = bi;
      for (int j = 0; j <= i; j++) begin
        term = term & p[j];
      end
      brw[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p[m];
        end
        brw[i+1] = brw[i+1] | term;
      end
    end
    dv = a ^ b ^ brw[GROUP-1:0];
    return {brw[GROUP], dv};
  endfunction

  logic en;

  assign en              = ~bus_io.out_valid | bus_io.out_ready;
  assign bus_io.in_ready = en;

  for (genvar k = 0; k < Stages; k++) begin : gen_stage
    localparam int unsigned Rem = WIDTH - k * GROUP;
    localparam int unsigned Dw  = (k + 1) * GROUP;

    logic [Rem-1:0] a_in;
    logic [Rem-1:0] b_in;
    logic           bin_s;
    logic           vld_s;
    logic [GROUP:0] res;
    logic [Dw-1:0]  dif_d;
    logic [Dw-1:0]  dif_q;
    logic           vld_q;
    logic           brw_q;

    if (k == 0) begin : gen_first
      assign a_in  = bus_io.a;
      assign b_in  = bus_io.b;
      assign bin_s = bus_io.bin;
      assign vld_s = bus_io.in_valid;
    end else begin : gen_next
      assign a_in  = gen_stage[k-1].gen_fwd.a_up_q;
      assign b_in  = gen_stage[k-1].gen_fwd.b_up_q;
      assign bin_s = gen_stage[k-1].brw_q;
      assign vld_s = gen_stage[k-1].vld_q;
    end

    assign res = bls_group(a_in[GROUP-1:0], b_in[GROUP-1:0], bin_s);

    if (k == 0) begin : gen_dif_first
      assign dif_d = res[GROUP-1:0];
    end else begin : gen_dif_next
      assign dif_d = {res[GROUP-1:0], gen_stage[k-1].dif_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        brw_q <= 1'b0;
        dif_q <= '0;
      end else if (en) begin
        vld_q <= vld_s;
        brw_q <= res[GROUP];
        dif_q <= dif_d;
      end
    end

    if (k == Stages - 1) begin : gen_last
      logic ovf_d;
      logic ovf_q;

      // Operand MSBs arrive here as the top bits of the skewed operand slice.
      assign ovf_d = (a_in[Rem-1] ^ b_in[Rem-1]) & (res[GROUP-1] ^ a_in[Rem-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_d;
        end
      end

      assign bus_io.out_valid = vld_q;
      assign bus_io.d         = dif_q;
      assign bus_io.bout      = brw_q;
      assign bus_io.ovf       = ovf_q;
    end else begin : gen_fwd
      logic [Rem-GROUP-1:0] a_up_q;
      logic [Rem-GROUP-1:0] b_up_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_up_q <= '0;
          b_up_q <= '0;
        end else if (en) begin
          a_up_q <= a_in[Rem-1:GROUP];
          b_up_q <= b_in[Rem-1:GROUP];
        end
      end
    end
  end

endmodule
